// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if
//   Load handshake between a value producer and seg_scan_driver.
//   Signals:
//     value_valid : producer offers a new binary value
//     value       : unsigned binary value (DATA_W bits)
//     value_ready : converter idle; transfer when valid && ready
//   Modports: master (producer side), slave (seg_scan_driver side).
interface seg_scan_driver_if #(
    parameter int DATA_W = 16
);
    logic              value_valid;
    logic [DATA_W-1:0] value;
    logic              value_ready;

    modport master (output value_valid, output value, input value_ready);
    modport slave  (input value_valid, input value, output value_ready);
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Converts a binary value to BCD with an iterative double-dabble FSM
//   (IDLE -> SHIFT x DATA_W -> COMMIT) and time-multiplexes the result
//   onto a common-segment 7-segment display, MSD first.
//   Ports:
//     clk, reset  : single clock, synchronous active-high reset
//     load        : slave side of seg_scan_driver_if (value handshake)
//     dp_mask     : live decimal-point enables, bit i -> digit[i]
//     digit       : one-hot digit enable (registered)
//     seg_data    : segments {g,f,e,d,c,b,a} (registered)
//     seg_dp      : decimal point of the active digit (registered)
//     update_done : one-cycle pulse when new display contents appear
//     overflow    : committed value does not fit in NUM_DIGITS digits
//   Build option: define SEG_LEADING_ZERO_BLANK_EN to blank leading zeros.
module seg_scan_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int DATA_W      = 16,
    parameter int REFRESH_DIV = 131072
) (
    input  logic                  clk,
    input  logic                  reset,
    seg_scan_driver_if.slave      load,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic [NUM_DIGITS-1:0] digit,
    output logic [6:0]            seg_data,
    output logic                  seg_dp,
    output logic                  update_done,
    output logic                  overflow
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(DATA_W);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);
    localparam logic [6:0]  DASH  = 7'b1000000;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [6:0]  RST_SEG = 7'b0000000;
`else
    localparam logic [6:0]  RST_SEG = 7'b0111111;
`endif

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b0111111;
            4'd1:    seg_code = 7'b0000110;
            4'd2:    seg_code = 7'b1011011;
            4'd3:    seg_code = 7'b1001111;
            4'd4:    seg_code = 7'b1100110;
            4'd5:    seg_code = 7'b1101101;
            4'd6:    seg_code = 7'b1111101;
            4'd7:    seg_code = 7'b0100111;
            4'd8:    seg_code = 7'b1111111;
            4'd9:    seg_code = 7'b1101111;
            default: seg_code = 7'b0000000;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
    state_t state, state_next;

    logic                  ready_int, done_int, accept, last_bit;
    logic [DATA_W-1:0]     shreg;
    logic [CNT_W-1:0]      bit_cnt;
    logic [BCD_W-1:0]      bcd, adj, bcd_next;
    logic                  ovf_pend;
    logic [BCD_W-1:0]      disp_bcd;
    logic                  disp_ovf;
    logic [PRE_W-1:0]      presc;
    logic [IDX_W-1:0]      scan_idx;
    logic [3:0]            cur_nib;
    logic                  blank;
    logic [6:0]            seg_cur;
    logic [NUM_DIGITS-1:0] digit_q;
    logic [6:0]            seg_q;
    logic                  dp_q;

    // ---------------- converter FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));

    always_comb begin
        state_next = state;
        ready_int  = 1'b0;
        done_int   = 1'b0;
        case (state)
            IDLE: begin
                ready_int = 1'b1;
                if (load.value_valid) state_next = SHIFT;
            end
            SHIFT:  if (last_bit) state_next = COMMIT;
            COMMIT: begin
                done_int   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = ready_int & load.value_valid;

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
    always_comb begin
        adj = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        end
        bcd_next = BCD_W'({adj, shreg[DATA_W-1]});
    end

    // The display register is written on the edge that enters COMMIT, so the
    // new contents and the update_done pulse appear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            bcd      <= '0;
            ovf_pend <= 1'b0;
            disp_bcd <= '0;
            disp_ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    shreg    <= load.value;
                    bcd      <= '0;
                    bit_cnt  <= '0;
                    ovf_pend <= (64'(load.value) >= LIMIT);
                end
                SHIFT: begin
                    shreg   <= shreg << 1;
                    bcd     <= bcd_next;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (last_bit) begin
                        disp_bcd <= bcd_next;
                        disp_ovf <= ovf_pend;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- scan ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            presc    <= '0;
            scan_idx <= IDX_W'(NUM_DIGITS - 1);
        end else if (presc == PRE_W'(REFRESH_DIV - 1)) begin
            presc    <= '0;
            scan_idx <= (scan_idx == '0) ? IDX_W'(NUM_DIGITS - 1) : scan_idx - 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lead_zero;
    // lead_zero[i]: digit i and every digit above it are zero.
    always_comb begin
        lead_zero = '0;
        lead_zero[NUM_DIGITS-1] = (disp_bcd[BCD_W-1 -: 4] == 4'd0);
        for (int unsigned i = NUM_DIGITS - 1; i > 0; i--) begin
            lead_zero[i-1] = lead_zero[i] && (disp_bcd[4*(i-1) +: 4] == 4'd0);
        end
    end
`endif

    always_comb begin
        cur_nib = '0;
        blank   = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                cur_nib = disp_bcd[4*i +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
                blank = (i != 0) && lead_zero[i];
`endif
            end
        end
        if (disp_ovf)   seg_cur = DASH;
        else if (blank) seg_cur = '0;
        else            seg_cur = seg_code(cur_nib);
    end

    // Reset loads what the reset-time scan index (MSD) and zero display would give,
    // so the MSD is selected in the first cycle after release.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= NUM_DIGITS'(1) << (NUM_DIGITS - 1);
            seg_q   <= RST_SEG;
            dp_q    <= dp_mask[NUM_DIGITS-1];
        end else begin
            digit_q <= NUM_DIGITS'(1) << scan_idx;
            seg_q   <= seg_cur;
            dp_q    <= dp_mask[scan_idx];
        end
    end

    assign load.value_ready = ready_int & ~reset;
    assign update_done      = done_int & ~reset;
    assign overflow         = disp_ovf & ~reset;
    assign digit            = reset ? '0 : digit_q;
    assign seg_data         = reset ? '0 : seg_q;
    assign seg_dp           = dp_q & ~reset;
endmodule
